// File: rtl/alu_multicycle.sv
// alu_multicycle: EX-stage ALU with a registered result and valid/ready
// handshakes on both sides. Single-cycle ops finish one cycle after accept.
// MUL is an iterative unsigned shift-add that handles one multiplier bit per
// cycle. Define ALU_DIVU_EN to add DIVU/REMU, an unsigned restoring divider
// that takes WIDTH cycles. Without it, opcodes 1110/1111 are illegal.
//
// Handshake: an input op transfers on a rising edge where in_valid && in_ready.
// A result transfers on a rising edge where out_valid && out_ready. While
// out_valid is high, result and flags stay stable. in_ready is high only in
// IDLE. The producer holds in_valid and its operands until accepted.
// out_ready is ignored while out_valid is low.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic [1:0]       o_dbg_state
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [OPW-1:0] OP_AND = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_OR  = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4'b0011);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0110);
  localparam logic [OPW-1:0] OP_SLT = OPW'(4'b0111);
  localparam logic [OPW-1:0] OP_SLL = OPW'(4'b1000);
  localparam logic [OPW-1:0] OP_SRL = OPW'(4'b1001);
  localparam logic [OPW-1:0] OP_SRA = OPW'(4'b1010);
  localparam logic [OPW-1:0] OP_NOR = OPW'(4'b1100);
  localparam logic [OPW-1:0] OP_MUL = OPW'(4'b1101);
`ifdef ALU_DIVU_EN
  localparam logic [OPW-1:0] OP_DIVU = OPW'(4'b1110);
  localparam logic [OPW-1:0] OP_REMU = OPW'(4'b1111);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_illegal;
  logic [SHW-1:0]   r_cnt;
  // Iterative datapath. For MUL, r_acc is the partial product, r_mcand is
  // the multiplicand (shifts left) and r_mplier is the multiplier (shifts
  // right). For the divider, r_acc is the partial remainder, r_mcand is the
  // divisor and r_mplier is the dividend that turns into the quotient.
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_illegal;
  logic             w_is_mul;
  logic             w_is_multi;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH-1:0] w_busy_res;
  logic             w_last_step;

  assign w_sum       = a + b;
  assign w_diff      = a - b;
  assign w_is_mul    = (aluop == OP_MUL);
  assign w_mul_acc   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last_step = (r_cnt == SHW'(WIDTH - 1));

`ifdef ALU_DIVU_EN
  logic             r_mul_sel;
  logic             r_rem_sel;
  logic             w_is_div;
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH:0]   w_div_sub;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  assign w_is_div    = (aluop == OP_DIVU) || (aluop == OP_REMU);
  assign w_is_multi  = w_is_mul || w_is_div;
  // Restoring step: shift the next dividend bit into the remainder, then
  // subtract the divisor when it fits. A zero divisor always fits, which
  // gives an all-ones quotient and a remainder equal to the dividend.
  assign w_div_shift = {r_acc, r_mplier[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_mcand});
  assign w_div_sub   = w_div_shift - {1'b0, r_mcand};
  assign w_rem_next  = w_div_ge ? w_div_sub[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
  assign w_quo_next  = {r_mplier[WIDTH-2:0], w_div_ge};
  assign w_busy_res  = r_mul_sel ? w_mul_acc : (r_rem_sel ? w_rem_next : w_quo_next);
`else
  assign w_is_multi  = w_is_mul;
  assign w_busy_res  = w_mul_acc;
`endif

  // Single-cycle result, overflow and illegal-opcode decode.
  always_comb begin
    w_res     = '0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    case (aluop)
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_NOR: w_res = ~(a | b);
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: w_res = a << b[SHW-1:0];
      OP_SRL: w_res = a >> b[SHW-1:0];
      OP_SRA: w_res = $signed(a) >>> b[SHW-1:0];
      OP_MUL: w_illegal = 1'b0;
`ifdef ALU_DIVU_EN
      OP_DIVU: w_illegal = 1'b0;
      OP_REMU: w_illegal = 1'b0;
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  // Control FSM. It also owns the iterative datapath and the registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_illegal   <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
`ifdef ALU_DIVU_EN
      r_mul_sel   <= 1'b0;
      r_rem_sel   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_is_multi) begin
              r_state <= S_BUSY;
              r_cnt   <= '0;
              r_acc   <= '0;
`ifdef ALU_DIVU_EN
              r_mul_sel <= w_is_mul;
              r_rem_sel <= (aluop == OP_REMU);
              if (w_is_mul) begin
                r_mcand  <= a;
                r_mplier <= b;
              end else begin
                r_mcand  <= b;
                r_mplier <= a;
              end
`else
              r_mcand  <= a;
              r_mplier <= b;
`endif
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_zero      <= (w_res == '0);
              r_ovf       <= w_ovf;
              r_illegal   <= w_illegal;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + SHW'(1);
`ifdef ALU_DIVU_EN
          if (r_mul_sel) begin
            r_acc    <= w_mul_acc;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end else begin
            r_acc    <= w_rem_next;
            r_mplier <= w_quo_next;
          end
`else
          r_acc    <= w_mul_acc;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
`endif
          if (w_last_step) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_busy_res;
            r_zero      <= (w_busy_res == '0);
            r_ovf       <= 1'b0;
            r_illegal   <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign zero        = r_zero;
  assign ovf         = r_ovf;
  assign illegal     = r_illegal;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle (WIDTH=32). It runs a vector table, hand-written
// multi-cycle sequences, and random ops that are checked against an
// arithmetic reference model.
module tb_alu_multicycle;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluop;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        ovf;
  logic        illegal;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  alu_multicycle #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .aluop(aluop),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf), .illegal(illegal),
    .o_dbg_state(dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        v;
    logic        il;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model computed from the opcode definitions.
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic v, output logic il,
                                  output int lat);
    longint s;
    r = 32'h0; v = 1'b0; il = 1'b0; lat = 1;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0011: r = x ^ y;
      4'b1100: r = ~(x | y);
      4'b0010: begin
        s = longint'($signed(x)) + longint'($signed(y));
        r = x + y;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s = longint'($signed(x)) - longint'($signed(y));
        r = x - y;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1000: r = x << y[4:0];
      4'b1001: r = x >> y[4:0];
      4'b1010: r = $signed(x) >>> y[4:0];
      4'b1101: begin
        r = 32'((64'(x) * 64'(y)));
        lat = 33;
      end
`ifdef ALU_DIVU_EN
      4'b1110: begin r = (y == 0) ? 32'hFFFF_FFFF : x / y; lat = 33; end
      4'b1111: begin r = (y == 0) ? x : x % y; lat = 33; end
`endif
      default: il = 1'b1;
    endcase
  endfunction

  // Driver: present one op, wait for the result, then take it. Enters and
  // leaves 1ns after a rising edge. After accept the operand buses are
  // scrambled to show that the operands were captured at accept.
  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic z, output logic v,
                       output logic il, output int lat, output int busy);
    int n;
    in_valid = 1'b1; aluop = op; a = x; b = y;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; aluop = 4'($urandom_range(0, 15));
    lat = 1; busy = 0;
    while (!out_valid && lat < 200) begin
      if (!in_ready) busy++;
      @(posedge clk); #1; lat++;
    end
    r = result; z = zero; v = ovf; il = illegal;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [31:0] r_got;
  logic        z_got, v_got, il_got;
  int          lat_got, busy_got;
  logic [31:0] r_exp;
  logic        v_exp, il_exp;
  int          lat_exp;
  int          cnt;
  logic        stable;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; aluop = '0;

    // Reset for two cycles, then release.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset result", 64'(result), 64'd0);
    check("reset flags", {61'd0, zero, ovf, illegal}, 64'd0);

    // Vector table.
    tbl.push_back('{4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'b0110, 32'h5,         32'h5,         32'h0,         1'b1, 1'b0, 1'b0});
    tbl.push_back('{4'b1100, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'b0111, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'b0111, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 1'b0});
    tbl.push_back('{4'b1000, 32'h1,         32'h23,        32'h8,         1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'b1001, 32'h8000_0000, 32'd31,        32'h1,         1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'b1010, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'b0110, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'b0010, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 1'b0});
    tbl.push_back('{4'b1011, 32'h1234,      32'h5678,      32'h0,         1'b1, 1'b0, 1'b1});
    tbl.push_back('{4'b1101, 32'h12345,     32'h100,       32'h0123_4500, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'b1101, 32'h8000_0000, 32'h2,         32'h0,         1'b1, 1'b0, 1'b0});
`ifdef ALU_DIVU_EN
    tbl.push_back('{4'b1110, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'b1111, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'b1110, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'b1111, 32'h1234_5678, 32'd0,         32'h1234_5678, 1'b0, 1'b0, 1'b0});
`else
    tbl.push_back('{4'b1110, 32'd100,       32'd7,         32'h0,         1'b1, 1'b0, 1'b1});
    tbl.push_back('{4'b1111, 32'd100,       32'd7,         32'h0,         1'b1, 1'b0, 1'b1});
`endif

    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, r_got, z_got, v_got, il_got, lat_got, busy_got);
      lat_exp = (tbl[i].op == 4'b1101) ? 33 : 1;
`ifdef ALU_DIVU_EN
      if (tbl[i].op == 4'b1110 || tbl[i].op == 4'b1111) lat_exp = 33;
`endif
      check($sformatf("vec%0d result", i), 64'(r_got), 64'(tbl[i].res));
      check($sformatf("vec%0d zero", i), 64'(z_got), 64'(tbl[i].z));
      check($sformatf("vec%0d ovf", i), 64'(v_got), 64'(tbl[i].v));
      check($sformatf("vec%0d illegal", i), 64'(il_got), 64'(tbl[i].il));
      check($sformatf("vec%0d latency", i), 64'(lat_got), 64'(lat_exp));
      check($sformatf("vec%0d busy cycles", i), 64'(busy_got), 64'(lat_exp - 1));
      check($sformatf("vec%0d in_ready after take", i), 64'(in_ready), 64'd1);
    end

    // out_ready with no result pending is ignored.
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle out_ready out_valid", 64'(out_valid), 64'd0);
    check("idle out_ready in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;

    // Reset in the middle of a MUL aborts it with no output.
    in_valid = 1'b1; aluop = 4'b1101; a = 32'h12345; b = 32'h100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid-mul busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid-mul reset in_ready", 64'(in_ready), 64'd1);
    check("mid-mul reset result", 64'(result), 64'd0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) cnt++;
      @(posedge clk); #1;
    end
    check("mid-mul no out_valid", 64'(cnt), 64'd0);

    // Backpressure: SLT result held while out_ready stays low. A second op
    // presented meanwhile must wait.
    in_valid = 1'b1; aluop = 4'b0111; a = 32'hFFFF_FFFF; b = 32'h1;
    @(posedge clk); #1;
    aluop = 4'b0010; a = 32'd3; b = 32'd4;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!(out_valid && result == 32'h1 && !in_ready)) stable = 1'b0;
      @(posedge clk); #1;
    end
    check("backpressure hold", 64'(stable), 64'd1);
    check("backpressure result", 64'(result), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release out_valid", 64'(out_valid), 64'd0);
    check("bp release in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp next op valid", 64'(out_valid), 64'd1);
    check("bp next op result", 64'(result), 64'd7);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Random ops checked against the model.
    for (int k = 0; k < 150; k++) begin
      logic [3:0]  op;
      logic [31:0] x, y;
      op = 4'($urandom_range(0, 15));
      x  = $urandom;
      y  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      ref_alu(op, x, y, r_exp, v_exp, il_exp, lat_exp);
      issue(op, x, y, r_got, z_got, v_got, il_got, lat_got, busy_got);
      check($sformatf("rand%0d op%b result", k, op), 64'(r_got), 64'(r_exp));
      check($sformatf("rand%0d op%b flags", k, op), {61'd0, z_got, v_got, il_got},
            {61'd0, (r_exp == 32'h0), v_exp, il_exp});
      check($sformatf("rand%0d op%b latency", k, op), 64'(lat_got), 64'(lat_exp));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
